// File: rtl/bp_be_rolly_fifo_if.sv
// Enqueue/dequeue/commit bundle for the rollback-capable FIFO.
// The slave modport is the FIFO side; the master modport is the producer/consumer side.
interface bp_be_rolly_fifo_if #(
  parameter int width_p      = 64,
  parameter int els_p        = 8,
  parameter int commit_max_p = 2
);
  localparam int ckpt_w_lp = $clog2(commit_max_p+1);
  localparam int cnt_w_lp  = $clog2(els_p+1);

  logic [width_p-1:0]   data_i;
  logic                 v_i;
  logic                 ready_o;
  logic [width_p-1:0]   data_o;
  logic                 v_o;
  logic                 yumi_i;
  logic                 ckpt_v_i;
  logic [ckpt_w_lp-1:0] ckpt_n_i;
  logic                 roll_v_i;
  logic                 clr_v_i;
  logic [cnt_w_lp-1:0]  count_o;
  logic [cnt_w_lp-1:0]  inflight_o;

  modport slave (
    input  data_i, v_i, yumi_i, ckpt_v_i, ckpt_n_i, roll_v_i, clr_v_i,
    output ready_o, data_o, v_o, count_o, inflight_o
  );

  modport master (
    output data_i, v_i, yumi_i, ckpt_v_i, ckpt_n_i, roll_v_i, clr_v_i,
    input  ready_o, data_o, v_o, count_o, inflight_o
  );
endinterface

// File: rtl/bp_be_rolly_fifo.sv
// FIFO with speculative reads: entries stay allocated until committed, and the
// read pointer can be rolled back to the commit pointer to replay them.
module bp_be_rolly_fifo #(
  parameter int width_p      = 64,
  parameter int els_p        = 8,
  parameter int commit_max_p = 2
) (
  input logic               clk_i,
  input logic               reset_n_i,
  bp_be_rolly_fifo_if.slave io
);
  localparam int lg_els_lp = $clog2(els_p);
  localparam int ptr_w_lp  = lg_els_lp + 1;
  localparam int cnt_w_lp  = $clog2(els_p+1);

  typedef logic [ptr_w_lp-1:0] ptr_t;

  ptr_t wptr_q, wptr_d;
  ptr_t rptr_q, rptr_d;
  ptr_t cptr_q, cptr_d;
  ptr_t occ, infl, yumi_inc, ckpt_inc;
  logic enq;

  logic [width_p-1:0] mem_q [els_p];

  // Extra pointer MSB separates full (distance els_p) from empty (distance 0).
  assign occ  = wptr_q - cptr_q;
  assign infl = rptr_q - cptr_q;

  assign io.ready_o    = (occ != ptr_t'(els_p));
  assign io.v_o        = (rptr_q != wptr_q);
  assign io.data_o     = mem_q[rptr_q[lg_els_lp-1:0]];
  assign io.count_o    = cnt_w_lp'(occ);
  assign io.inflight_o = cnt_w_lp'(infl);

  assign enq      = io.v_i & io.ready_o;
  assign yumi_inc = ptr_t'(io.yumi_i);
  assign ckpt_inc = ptr_t'(io.ckpt_n_i);

  always_comb begin
    wptr_d = wptr_q + ptr_t'(enq);
    cptr_d = cptr_q;
    if (io.clr_v_i)       cptr_d = rptr_q + yumi_inc;
    else if (io.ckpt_v_i) cptr_d = cptr_q + ckpt_inc;
    // Rollback lands on the post-commit pointer, dropping any same-cycle yumi.
    rptr_d = rptr_q + yumi_inc;
    if (io.roll_v_i && !io.clr_v_i) rptr_d = cptr_d;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cptr_q <= cptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wptr_q[lg_els_lp-1:0]] <= io.data_i;
  end

  a_yumi_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    io.yumi_i |-> io.v_o);

  a_ckpt_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (io.ckpt_v_i && !io.clr_v_i) |->
      ((int'(io.ckpt_n_i) <= int'(infl) + int'(io.yumi_i)) &&
       (int'(io.ckpt_n_i) <= commit_max_p)));
endmodule

// File: tb/tb_bp_be_rolly_fifo.sv
// Directed bench for the rollback FIFO at width 16, depth 8, commit 2.
module tb_bp_be_rolly_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_err = 0;

  bp_be_rolly_fifo_if #(.width_p(16), .els_p(8), .commit_max_p(2)) bus ();

  bp_be_rolly_fifo #(.width_p(16), .els_p(8), .commit_max_p(2)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .io(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic idle();
    bus.v_i = 0; bus.data_i = '0; bus.yumi_i = 0; bus.ckpt_v_i = 0;
    bus.ckpt_n_i = '0; bus.roll_v_i = 0; bus.clr_v_i = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic enq(input logic [15:0] d);
    idle(); bus.v_i = 1; bus.data_i = d; tick(); idle();
  endtask

  task automatic do_reset();
    idle();
    @(negedge clk); rst_n = 0;
    @(negedge clk); rst_n = 1;
    #1;
  endtask

  initial begin
    idle();
    #3;
    chk("rst_ready", bus.ready_o, 1);
    chk("rst_v", bus.v_o, 0);
    chk("rst_count", bus.count_o, 0);
    chk("rst_infl", bus.inflight_o, 0);
    @(negedge clk); rst_n = 1;

    // first enqueue accepted on first edge after reset release
    enq(16'h0001);
    chk("first_enq_count", bus.count_o, 1);
    chk("first_enq_data", bus.data_o, 16'h0001);
    for (int i = 2; i <= 8; i++) enq(16'(i));
    chk("full_ready", bus.ready_o, 0);
    chk("full_count", bus.count_o, 8);
    enq(16'h0009);
    chk("drop_count", bus.count_o, 8);
    chk("drop_data", bus.data_o, 16'h0001);
    idle(); bus.yumi_i = 1; bus.ckpt_v_i = 1; bus.ckpt_n_i = 2'd1; tick(); idle();
    chk("commit_ready", bus.ready_o, 1);
    chk("commit_count", bus.count_o, 7);
    chk("commit_data", bus.data_o, 16'h0002);
    // ckpt_n=0 is a no-op
    idle(); bus.ckpt_v_i = 1; bus.ckpt_n_i = 2'd0; tick(); idle();
    chk("ckpt0_count", bus.count_o, 7);

    // rollback replay
    do_reset();
    enq(16'h00A0); enq(16'h00B0); enq(16'h00C0);
    chk("rb_v", bus.v_o, 1);
    chk("rb_pre_a", bus.data_o, 16'h00A0);
    bus.yumi_i = 1; tick();
    chk("rb_pre_b", bus.data_o, 16'h00B0);
    tick(); idle();
    chk("rb_infl2", bus.inflight_o, 2);
    bus.roll_v_i = 1; tick(); idle();
    chk("rb_data", bus.data_o, 16'h00A0);
    chk("rb_infl", bus.inflight_o, 0);
    chk("rb_count", bus.count_o, 3);
    bus.yumi_i = 1;
    chk("rb_re_a", bus.data_o, 16'h00A0); tick();
    chk("rb_re_b", bus.data_o, 16'h00B0); tick();
    chk("rb_re_c", bus.data_o, 16'h00C0); tick(); idle();
    chk("rb_re_v", bus.v_o, 0);
    chk("rb_re_infl", bus.inflight_o, 3);

    // commit 2 with same-cycle rollback
    do_reset();
    enq(16'h00A1); enq(16'h00B1); enq(16'h00C1);
    bus.yumi_i = 1; tick(); tick(); tick(); idle();
    chk("cr_infl3", bus.inflight_o, 3);
    bus.ckpt_v_i = 1; bus.ckpt_n_i = 2'd2; bus.roll_v_i = 1; tick(); idle();
    chk("cr_data", bus.data_o, 16'h00C1);
    chk("cr_count", bus.count_o, 1);
    chk("cr_infl", bus.inflight_o, 0);

    // roll with yumi: yumi discarded
    bus.yumi_i = 1; bus.roll_v_i = 1; tick(); idle();
    chk("ry_data", bus.data_o, 16'h00C1);
    chk("ry_infl", bus.inflight_o, 0);

    // clr beats roll
    do_reset();
    enq(16'h00A2); enq(16'h00B2); enq(16'h00C2);
    bus.yumi_i = 1; tick(); tick();
    bus.clr_v_i = 1; bus.roll_v_i = 1; tick(); idle();
    chk("clr_count", bus.count_o, 0);
    chk("clr_infl", bus.inflight_o, 0);
    chk("clr_v", bus.v_o, 0);
    chk("clr_ready", bus.ready_o, 1);

    // wrap
    do_reset();
    for (int i = 0; i < 20; i++) begin
      enq(16'h0100 + 16'(i));
      chk("wrap_v", bus.v_o, 1);
      chk("wrap_data", bus.data_o, 16'h0100 + 16'(i));
      bus.yumi_i = 1; bus.ckpt_v_i = 1; bus.ckpt_n_i = 2'd1; tick(); idle();
      chk("wrap_count", bus.count_o, 0);
      chk("wrap_ready", bus.ready_o, 1);
      chk("wrap_empty", bus.v_o, 0);
    end

    // async reset mid-operation
    do_reset();
    for (int i = 0; i < 5; i++) enq(16'h0D00 + 16'(i));
    bus.yumi_i = 1; tick(); tick(); tick(); idle();
    chk("mr_infl", bus.inflight_o, 3);
    chk("mr_count", bus.count_o, 5);
    #2; rst_n = 0; #1;
    chk("mr_ready", bus.ready_o, 1);
    chk("mr_v", bus.v_o, 0);
    chk("mr_count0", bus.count_o, 0);
    chk("mr_infl0", bus.inflight_o, 0);
    @(negedge clk); rst_n = 1;
    tick();
    chk("mr_still_empty", bus.v_o, 0);
    enq(16'h0BEE);
    chk("mr_new_count", bus.count_o, 1);
    chk("mr_new_data", bus.data_o, 16'h0BEE);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/bp_be_rolly_fifo.md
BP_BE_ROLLY_FIFO -- requirements
Module: bp_be_rolly_fifo

Interface
REQ-001 SHALL have parameter width_p, default 64: entry width in bits.
REQ-002 SHALL have parameter els_p, default 8: depth; power of two, >= 2.
REQ-003 SHALL have parameter commit_max_p, default 2: max entries committed per cycle, 1..els_p.
REQ-004 SHALL have ports:
 clk_i  in  1  sole clock, all state on rising edge
 reset_n_i  in  1  asynchronous, active-low reset
 data_i  in  width_p  enqueue data
 v_i  in  1  enqueue valid
 ready_o  out  1  enqueue ready
 data_o  out  width_p  entry at read pointer
 v_o  out  1  data_o valid
 yumi_i  in  1  speculative dequeue; legal only when v_o=1
 ckpt_v_i  in  1  commit request
 ckpt_n_i  in  clog2(commit_max_p+1)  number of entries to commit
 roll_v_i  in  1  rollback read pointer to commit pointer
 clr_v_i  in  1  commit everything read so far
 count_o  out  clog2(els_p+1)  occupied entries (wptr-cptr)
 inflight_o  out  clog2(els_p+1)  read-but-uncommitted entries (rptr-cptr)

Function
REQ-005 SHALL keep three pointers wptr, rptr, cptr, each clog2(els_p)+1 bits, modulo 2*els_p; storage index is low clog2(els_p) bits.
REQ-006 SHALL maintain invariant cptr <= rptr <= wptr (modular distance), wptr-cptr <= els_p.
REQ-007 ready_o SHALL be (wptr-cptr) != els_p, from registered state only; no dependence on same-cycle ckpt/clr/roll.
REQ-008 enqueue fires when v_i & ready_o: write data_i at wptr, wptr += 1; v_i with ready_o=0 SHALL be dropped without state change.
REQ-009 v_o SHALL be rptr != wptr; data_o SHALL be storage[rptr] combinationally; no write-to-read bypass (entry enqueued in cycle N visible no earlier than N+1).
REQ-010 Next cptr: clr_v_i=1 -> rptr + yumi_i; else ckpt_v_i=1 -> cptr + ckpt_n_i; else unchanged.
REQ-011 Next rptr: roll_v_i=1 and clr_v_i=0 -> next cptr (per REQ-010, includes same-cycle ckpt); else rptr + yumi_i.
REQ-012 clr_v_i and roll_v_i together: clr SHALL win; rollback ignored.
REQ-013 roll_v_i with yumi_i same cycle: yumi SHALL be discarded (entry replays).
REQ-014 ckpt_n_i=0 with ckpt_v_i=1 SHALL be a no-op; ckpt_n_i > inflight_o + yumi_i or > commit_max_p SHALL be illegal, flagged by simulation assertion, state undefined.
REQ-015 yumi_i=1 with v_o=0 SHALL be illegal, flagged by assertion.
REQ-016 Committed entries free storage the following cycle (ready_o rises cycle after commit when full).
REQ-017 count_o, inflight_o SHALL be combinational from registered pointers.
REQ-018 Pointer wrap SHALL be seamless across 2*els_p; full vs empty distinguished by MSB.
REQ-019 Storage SHALL be flops or 1r1w RAM with async read; contents not reset.

Reset
REQ-020 On reset_n_i=0 (asynchronous, any cycle incl. mid-operation): wptr=rptr=cptr=0; ready_o=1, v_o=0, count_o=0, inflight_o=0; all in-flight/uncommitted entries discarded.
REQ-021 First enqueue SHALL be accepted on the first rising edge after reset_n_i deasserts.

Verification (width_p=16, els_p=8, commit_max_p=2)
REQ-022 Fill: 8 enqueues 0x0001..0x0008, no dequeue -> ready_o=0, count_o=8, 9th enqueue dropped; one yumi + ckpt_n=1 -> ready_o=1 next cycle.
REQ-023 Rollback: enqueue A,B,C; yumi A,B; roll_v_i -> data_o=A, inflight_o=0, count_o=3; re-yumi A,B,C in order.
REQ-024 Commit+roll same cycle: read A,B,C; ckpt_n=2 with roll_v_i -> data_o=C, count_o=1, inflight_o=0.
REQ-025 Clr vs roll: read A,B, same cycle yumi C + clr_v_i + roll_v_i -> count_o=0, inflight_o=0, v_o=0.
REQ-026 Wrap: 20 enqueue/yumi/ckpt_n=1 rounds -> data order preserved, pointers wrap, no false full/empty.
REQ-027 Reset mid-operation: 5 entries, 3 read, assert reset_n_i asynchronously -> outputs at reset values immediately, prior data never reappears.
